// File: rtl/r5fp_idiv_pkg.sv
// Shared definitions for the radix-4 fractional integer divider:
// FSM states, digit width per step and the step-count helper.
package r5fp_idiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RADIX_BITS = 2;

  function automatic int step_count(input int w);
    return w / RADIX_BITS;
  endfunction

endpackage

// File: rtl/r5fp_idiv_r4_step.sv
// One radix-4 restoring step: shifts the partial remainder by one digit and
// subtracts the largest multiple of D (0..3) that keeps it non-negative.
module r5fp_idiv_r4_step
  import r5fp_idiv_pkg::*;
#(
  parameter int W = 26
) (
  input  logic [W+1:0] r,
  input  logic [W+1:0] d1,
  input  logic [W+1:0] d2,
  input  logic [W+1:0] d3,
  output logic [1:0]   q,
  output logic [W+1:0] r_next
);

  logic [W+1:0] t;
  logic [W+2:0] diff1, diff2, diff3;

  assign t = r << RADIX_BITS;

  // The extra top bit of each difference is a borrow: set means T < k*D.
  assign diff1 = {1'b0, t} - {1'b0, d1};
  assign diff2 = {1'b0, t} - {1'b0, d2};
  assign diff3 = {1'b0, t} - {1'b0, d3};

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    q      = 2'd0;
    r_next = t;
    if (!diff3[W+2]) begin
      q      = 2'd3;
      r_next = diff3[W+1:0];
    end else if (!diff2[W+2]) begin
      q      = 2'd2;
      r_next = diff2[W+1:0];
    end else if (!diff1[W+2]) begin
      q      = 2'd1;
      r_next = diff1[W+1:0];
    end
  end

endmodule

// File: rtl/r5fp_idiv_r4.sv
// Radix-4 restoring divider returning floor(N*2^W / D) and the final remainder
// over a strobe/ready/done handshake; two quotient bits retire per BUSY cycle.
module r5fp_idiv_r4
  import r5fp_idiv_pkg::*;
#(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] N_i,
  input  logic [W-1:0] D_i,
  input  logic         strobe_i,
  output logic [W-1:0] Quo_o,
  output logic [W-1:0] Rem_o,
  output logic         done_o,
  output logic         ready_o
);

  localparam int STEPS = step_count(W);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [W+1:0]     r;
  logic [W-1:0]     q_acc;
  logic [W-1:0]     d;
  logic [W+1:0]     d3;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     rem_q;

  logic [1:0]   digit;
  logic [W+1:0] r_next;
  logic [W-1:0] q_next;
  logic         accept;
  logic         last_step;

  assign accept    = strobe_i && (state != BUSY);
  assign last_step = (cnt == '0);
  assign q_next    = (q_acc << RADIX_BITS) | W'(digit);

  r5fp_idiv_r4_step #(.W(W)) u_step (
    .r      (r),
    .d1     ({2'b00, d}),
    .d2     ({1'b0, d, 1'b0}),
    .d3     (d3),
    .q      (digit),
    .r_next (r_next)
  );

  // NOTE: every register, datapath included, clears on reset so outputs read zero at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Separate result registers let Quo/Rem hold the previous answer while the
  // next operation is loaded; they only follow the datapath once steps begin.
  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      r     <= '0;
      q_acc <= '0;
      d     <= '0;
      d3    <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      cnt   <= CNT_W'(STEPS - 1);
      r     <= {2'b00, N_i};
      q_acc <= '0;
      d     <= D_i;
      d3    <= {2'b00, D_i} + {1'b0, D_i, 1'b0};
    end else if (state == BUSY) begin
      if (!last_step) cnt <= cnt - CNT_W'(1);
      r     <= r_next;
      q_acc <= q_next;
      quo_q <= q_next;
      rem_q <= r_next[W-1:0];
    end
  end

  assign Quo_o   = quo_q;
  assign Rem_o   = rem_q;
  assign done_o  = (state == DONE);
  assign ready_o = (state != BUSY);

endmodule

// File: doc/r5fp_idiv_r4.md
# r5fp_idiv_r4

Radix-4 restoring fractional integer divider serving the FP divide front-end over its `idiv_*` handshake. It receives the even-width normalised significand pair (N, D) and returns the W-bit quotient floor(N·2^W / D) and the final partial remainder. The FP front-end rounds with these results: quotient bits give the significand and round bit, and a non-zero remainder gives the sticky bit. It retires 2 quotient bits per cycle.

## Interface
- `W`, default 26: operand and quotient width (front-end ExtWidth). Must be even and ≥ 4.
- `clk`, input, 1: clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `N_i`, input, W: dividend. Precondition: N_i < D_i.
- `D_i`, input, W: divisor. Precondition: D_i[W-1:W-2] == 2'b01 (normalised).
- `strobe_i`, input, 1: start request. Accepted only when `ready_o`=1.
- `Quo_o`, output, W: quotient. Valid while `done_o`=1.
- `Rem_o`, output, W: final remainder. Valid while `done_o`=1.
- `done_o`, output, 1: one-cycle result pulse.
- `ready_o`, output, 1: able to accept `strobe_i`.

## Operation
- State machine IDLE, BUSY, DONE. `ready_o` = (state != BUSY).
- Accepting `strobe_i` (state IDLE or DONE) loads:
  - R ← {2'b00, N_i} (W+2 bits)
  - D ← D_i
  - Q ← 0
  - cnt ← W/2 − 1
  - state ← BUSY
- Each BUSY cycle performs one step:
  - T = 4R.
  - q = largest digit in {3, 2, 1, 0} with T − q·D ≥ 0. Compare against 3D, 2D and D in parallel; 3D = D + 2D is W+2 bits.
  - R ← T − q·D.
  - Q ← {Q[W-3:0], q}.
- With cnt = 0: state ← DONE. Otherwise cnt ← cnt − 1.
- DONE lasts one cycle: `done_o`=1, `Quo_o`=Q, `Rem_o`=R[W-1:0].
  - With no strobe, next state is IDLE.
  - With `strobe_i`=1, the new operation is loaded and the next state is BUSY (back-to-back).
- Result contract when preconditions hold:
  - Quo·D + Rem = N·2^W.
  - 0 ≤ Rem < D.
  - R < D is maintained each step, so q ≤ 3 and R never exceeds W bits after a step.
- Precondition violated (N ≥ D, or D not normalised, including D = 0): Quo/Rem are unspecified. Latency and handshake are unchanged, and no hang is permitted.
- `strobe_i` while BUSY is ignored. The in-flight operation is unaffected.
- `Quo_o`/`Rem_o` hold their values from DONE until the first BUSY step of the next operation. During BUSY they show intermediate values.

## Timing
- `strobe_i` sampled high at edge 0 → BUSY for edges 1..W/2 → `done_o` high for exactly the cycle after edge W/2. The default W=26 gives 13 BUSY cycles.
- Back-to-back throughput: one result per W/2+1 cycles.
- `ready_o` low exactly during the W/2 BUSY cycles.
- Reset values, effective immediately on `reset_n`=0:
  - state = IDLE
  - `done_o`=0, `ready_o`=1
  - `Quo_o`=0, `Rem_o`=0
  - cnt = 0
- Reset asserted mid-operation aborts it: no `done_o` is produced. `strobe_i` is accepted on the first edge with `reset_n`=1.
- No combinational path from `strobe_i` to any output.

## Structure
- Shared package `r5fp_idiv_pkg`:
  - state enum (IDLE, BUSY, DONE)
  - radix constant (2 bits per step)
  - function computing step count W/2
- Sub-module `r5fp_idiv_r4_step`, purely combinational:
  - inputs: R, D, 2D, 3D (W+2 bits)
  - outputs: digit q[1:0] and next R
  - three parallel subtractors plus priority select
- Top holds the FSM, counter, R/Q/D registers and the 3D precompute register. 3D is computed once at load.

## Test plan
All scenarios use W=26.
1. N=0x0800000, D=0x1000000, strobe at cycle 0 → `done_o` at cycle 14, Quo=0x2000000, Rem=0.
2. N=0x1FFFFFE, D=0x1FFFFFF → Quo=0x3FFFFFD, Rem=0x1FFFFFD.
3. N=0x1000000, D=0x1800000 → Quo=0x2AAAAAA, Rem=0x1000000.
4. Case 3, then case 1 strobed during its DONE cycle:
   - two `done_o` pulses 14 cycles apart with correct results
   - `ready_o` low for exactly 13 cycles between them
5. Case 2 running, then `strobe_i` with case 1 operands at BUSY cycle 5 → ignored; result is still case 2's.
6. `reset_n` low during BUSY cycle 5 (async, mid-cycle):
   - outputs zero and `ready_o`=1 immediately
   - no `done_o`
   - a fresh case 3 strobe after release yields the correct result 14 cycles later.
